// File: rtl/snn_fsm.sv
// Command/spike sequencer between the HPS PIO registers and the SNN core.
// Stages a 64-bit spike vector, commits it on command, and scans it out one neuron per cycle.
module snn_fsm #(
    parameter int         DATA_W     = 32,
    parameter logic [1:0] CMD_START  = 2'd1,
    parameter logic [1:0] CMD_COMMIT = 2'd2,
    parameter logic [1:0] CMD_CLEAR  = 2'd3
) (
    input  logic              CLOCK_50,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] command_in,
    input  logic              command_write,
    input  logic [DATA_W-1:0] spike_0_in,
    input  logic [DATA_W-1:0] spike_1_in,
    input  logic              spike_0_write,
    input  logic              spike_1_write,
    output logic              spike_out_valid,
    output logic [5:0]        spike_out_addr,
    output logic              busy,
    output logic              step_done,
    output logic [15:0]       step_count,
    output logic              cmd_error,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COMMIT = 2'd1,
        S_SCAN   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_cw_q;
    logic [2*DATA_W-1:0]   r_staged;
    logic [2*DATA_W-1:0]   r_active;
    logic [5:0]            r_idx;
    logic                  r_spk_valid;
    logic [5:0]            r_spk_addr;
    logic                  r_busy;
    logic                  r_step_done;
    logic [15:0]           r_step_count;
    logic                  r_cmd_error;

    logic                  w_cmd_pulse;
    logic [1:0]            w_code;
    logic                  w_cmd_real;

    // A held command strobe issues exactly once: only its rising edge counts.
    assign w_cmd_pulse = command_write & ~r_cw_q;
    assign w_code      = command_in[1:0];
    assign w_cmd_real  = w_cmd_pulse && (w_code != 2'd0);

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cw_q       <= 1'b0;
            r_staged     <= '0;
            r_active     <= '0;
            r_idx        <= '0;
            r_spk_valid  <= 1'b0;
            r_spk_addr   <= '0;
            r_busy       <= 1'b0;
            r_step_done  <= 1'b0;
            r_step_count <= '0;
            r_cmd_error  <= 1'b0;
        end else begin
            r_cw_q      <= command_write;
            r_step_done <= 1'b0;
            r_spk_valid <= 1'b0;
            r_spk_addr  <= '0;

            if (spike_0_write) r_staged[DATA_W-1:0]        <= spike_0_in;
            if (spike_1_write) r_staged[2*DATA_W-1:DATA_W] <= spike_1_in;

            if (w_cmd_real && (r_state != S_IDLE)) r_cmd_error <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_cmd_pulse) begin
                        case (w_code)
                            CMD_START: begin
                                r_state <= S_SCAN;
                                r_idx   <= '0;
                                r_busy  <= 1'b1;
                            end
                            CMD_COMMIT: begin
                                r_state <= S_COMMIT;
                                r_busy  <= 1'b1;
                            end
                            CMD_CLEAR: begin
                                // Clear overrides any spike write landing on the same edge.
                                r_staged     <= '0;
                                r_active     <= '0;
                                r_step_count <= '0;
                                r_cmd_error  <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_COMMIT: begin
                    r_active <= r_staged;
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                end
                S_SCAN: begin
                    r_spk_addr  <= r_idx;
                    r_spk_valid <= r_active[r_idx];
                    r_idx       <= r_idx + 6'd1;
                    if (r_idx == 6'd63) r_state <= S_DONE;
                end
                S_DONE: begin
                    r_step_done  <= 1'b1;
                    r_step_count <= r_step_count + 16'd1;
                    r_state      <= S_IDLE;
                    r_busy       <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign spike_out_valid = r_spk_valid;
    assign spike_out_addr  = r_spk_addr;
    assign busy            = r_busy;
    assign step_done       = r_step_done;
    assign step_count      = r_step_count;
    assign cmd_error       = r_cmd_error;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_snn_fsm.sv
// Directed bench for snn_fsm: staging, commit, scan, held/re-issued commands, clear and reset.
module tb_snn_fsm;

    logic        CLOCK_50;
    logic        rst_n;
    logic [31:0] command_in;
    logic        command_write;
    logic [31:0] spike_0_in;
    logic [31:0] spike_1_in;
    logic        spike_0_write;
    logic        spike_1_write;
    logic        spike_out_valid;
    logic [5:0]  spike_out_addr;
    logic        busy;
    logic        step_done;
    logic [15:0] step_count;
    logic        cmd_error;
    logic [1:0]  o_dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    snn_fsm dut (
        .CLOCK_50        (CLOCK_50),
        .rst_n           (rst_n),
        .command_in      (command_in),
        .command_write   (command_write),
        .spike_0_in      (spike_0_in),
        .spike_1_in      (spike_1_in),
        .spike_0_write   (spike_0_write),
        .spike_1_write   (spike_1_write),
        .spike_out_valid (spike_out_valid),
        .spike_out_addr  (spike_out_addr),
        .busy            (busy),
        .step_done       (step_done),
        .step_count      (step_count),
        .cmd_error       (cmd_error),
        .o_dbg_state     (o_dbg_state)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(negedge CLOCK_50);
    endtask

    // One-cycle command strobe; returns just after the accepting edge.
    task automatic issue_cmd(input logic [31:0] code);
        command_in    = code;
        command_write = 1'b1;
        tick();
        command_write = 1'b0;
    endtask

    // START then watch 80 edges; optional longer hold, re-issued START, and all-ones spike write.
    task automatic run_step(input int hold, input int recmd_at, input int spk_at,
                            output logic [63:0] seen, output int addr_err,
                            output int n_done, output int done_at);
        seen = '0; addr_err = 0; n_done = 0; done_at = -1;
        command_in    = 32'd1;
        command_write = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (i >= 1 && i <= 64 && spike_out_addr !== 6'(i - 1)) addr_err++;
            if (spike_out_valid) seen[spike_out_addr] = 1'b1;
            if (step_done) begin
                n_done++;
                done_at = i;
            end
            command_write = (i + 1 < hold) || (i + 1 == recmd_at);
            spike_0_in    = 32'hFFFF_FFFF;
            spike_1_in    = 32'hFFFF_FFFF;
            spike_0_write = (i + 1 == spk_at);
            spike_1_write = (i + 1 == spk_at);
        end
        command_write = 1'b0;
        spike_0_write = 1'b0;
        spike_1_write = 1'b0;
    endtask

    logic [63:0] seen;
    int          addr_err, n_done, done_at;

    initial begin
        rst_n = 1'b0;
        command_in = '0; command_write = 1'b0;
        spike_0_in = '0; spike_1_in = '0;
        spike_0_write = 1'b0; spike_1_write = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_valid", 64'(spike_out_valid), 64'd0);
        check("rst_addr",  64'(spike_out_addr),  64'd0);
        check("rst_busy",  64'(busy),            64'd0);
        check("rst_done",  64'(step_done),       64'd0);
        check("rst_count", 64'(step_count),      64'd0);
        check("rst_err",   64'(cmd_error),       64'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Both halves staged in one cycle, committed, then scanned
        spike_0_in = 32'h1; spike_1_in = 32'h2;
        spike_0_write = 1'b1; spike_1_write = 1'b1;
        tick();
        spike_0_write = 1'b0; spike_1_write = 1'b0;
        issue_cmd(32'd2);
        check("commit_busy1", 64'(busy), 64'd1);
        tick();
        check("commit_busy0", 64'(busy), 64'd0);
        run_step(1, -1, -1, seen, addr_err, n_done, done_at);
        check("t2_vector",  seen,              64'h0000_0002_0000_0001);
        check("t2_addrseq", 64'(addr_err),     64'd0);
        check("t2_ndone",   64'(n_done),       64'd1);
        check("t2_doneat",  64'(done_at),      64'd65);
        check("t2_count",   64'(step_count),   64'd1);
        check("t2_busy",    64'(busy),         64'd0);

        // Strobe held three cycles issues one scan only
        run_step(3, -1, -1, seen, addr_err, n_done, done_at);
        check("t3_vector",  seen,            64'h0000_0002_0000_0001);
        check("t3_ndone",   64'(n_done),     64'd1);
        check("t3_doneat",  64'(done_at),    64'd65);
        check("t3_count",   64'(step_count), 64'd2);
        check("t3_err",     64'(cmd_error),  64'd0);

        // START re-issued mid-scan is rejected and flagged
        run_step(1, 10, -1, seen, addr_err, n_done, done_at);
        check("t4_ndone",   64'(n_done),     64'd1);
        check("t4_addrseq", 64'(addr_err),   64'd0);
        check("t4_count",   64'(step_count), 64'd3);
        check("t4_err",     64'(cmd_error),  64'd1);

        // Spike writes during a scan only touch the staged vector
        run_step(1, -1, 20, seen, addr_err, n_done, done_at);
        check("t5_vector",  seen,            64'h0000_0002_0000_0001);
        check("t5_count",   64'(step_count), 64'd4);
        issue_cmd(32'd2);
        tick();
        run_step(1, -1, -1, seen, addr_err, n_done, done_at);
        check("t5_allones", seen,            64'hFFFF_FFFF_FFFF_FFFF);
        check("t5_count2",  64'(step_count), 64'd5);

        // CLEAR in IDLE wipes error, count and both vectors
        issue_cmd(32'd3);
        tick();
        check("clr_err",   64'(cmd_error),  64'd0);
        check("clr_count", 64'(step_count), 64'd0);
        check("clr_busy",  64'(busy),       64'd0);
        issue_cmd(32'd2);
        tick();
        run_step(1, -1, -1, seen, addr_err, n_done, done_at);
        check("clr_vector", seen,            64'd0);
        check("clr_count2", 64'(step_count), 64'd1);

        // Code 0 while busy is a NOP; CLEAR while busy is rejected
        issue_cmd(32'd1);
        repeat (3) tick();
        issue_cmd(32'd0);
        tick();
        check("nop_err", 64'(cmd_error), 64'd0);
        issue_cmd(32'd3);
        tick();
        check("busyclr_err",  64'(cmd_error),  64'd1);
        check("busyclr_cnt",  64'(step_count), 64'd1);
        check("busyclr_addr", 64'(spike_out_addr), 64'd6);

        // Asynchronous reset mid-scan
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_addr",  64'(spike_out_addr), 64'd0);
        check("mid_rst_busy",  64'(busy),           64'd0);
        check("mid_rst_err",   64'(cmd_error),      64'd0);
        check("mid_rst_count", 64'(step_count),     64'd0);
        check("mid_rst_state", 64'(o_dbg_state),    64'd0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        issue_cmd(32'd3);
        tick();
        check("post_rst_err",   64'(cmd_error),  64'd0);
        check("post_rst_count", 64'(step_count), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
